color_decoder: RTL and testbench

Streaming pixel decoder, the receive-side counterpart of the 1-bit color encoder. Accepts 24-bit RGB pixels, quantizes each to the RRRGGGBB 8-bit color code, and classifies it back to one data bit (color_0 → 0, color_1 → 1). Decoded bits are packed LSB-first into PACK_WIDTH-bit words for the 1-bit frame buffer. Sits between a pixel source (capture path or test pattern generator) and the frame buffer write port, with valid/ready on both sides.

---
 rtl/color_pkg.sv | 44 ++++
 rtl/pixel_packer.sv | 97 +++++++++
 rtl/color_decoder.sv | 102 ++++++++++
 tb/tb_color_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// ---------------------------------------------------------------------------
// color_pkg
// Shared definitions for the 1-bit color encoder/decoder pair.
//   - RRRGGGBB field positions and widths
//   - default color codes for data bit 0 and data bit 1
//   - 8-bit color code type
//   - packer state encoding
//   - color_dist(): Manhattan distance between two codes, measured on the
//     quantized fields (|dR3| + |dG3| + |dB2|)
// ---------------------------------------------------------------------------
package color_pkg;

    localparam int CODE_W = 8;

    localparam int R_LSB = 5;
    localparam int R_W   = 3;
    localparam int G_LSB = 2;
    localparam int G_W   = 3;
    localparam int B_LSB = 0;
    localparam int B_W   = 2;

    typedef logic [CODE_W-1:0] color_code_t;

    localparam color_code_t COLOR_0_DEF = 8'h1C;
    localparam color_code_t COLOR_1_DEF = 8'hFF;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pack_state_t;

    // Fields are at most 3 bits wide, so each term fits in 3 bits and the
    // sum (max 7+7+3) fits in 5.
    function automatic logic [4:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? 5'(a - b) : 5'(b - a);
    endfunction

    function automatic logic [4:0] color_dist(input color_code_t a, input color_code_t b);
        return abs_diff(a[R_LSB +: R_W], b[R_LSB +: R_W])
             + abs_diff(a[G_LSB +: G_W], b[G_LSB +: G_W])
             + abs_diff(3'(a[B_LSB +: B_W]), 3'(b[B_LSB +: B_W]));
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Packs a stream of decoded bits LSB-first into PACK_WIDTH-bit words and
// presents them on a valid/ready output register.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// PK_FILL | bit_idx advancing; incoming bits are shifted into the word
// PK_HOLD | out_valid=1 and the completing bit is waiting for out_ready
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   bit_valid/bit_accept  upstream handshake (bit_accept is combinational)
//   bit_value, bit_last   decoded bit and end-of-line marker
//   out_valid/out_ready   word handshake
//   out_data              packed bits, first bit in bit 0, unused bits 0
//   out_count             number of valid bits in out_data (1..PACK_WIDTH)
//   out_last              word ends a line
// ---------------------------------------------------------------------------
module pixel_packer
    import color_pkg::*;
#(
    parameter int PACK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  bit_value,
    input  logic                  bit_last,
    output logic                  bit_accept,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic [5:0]            out_count,
    output logic                  out_last
);

    localparam int IDX_W = $clog2(PACK_WIDTH);

    if (PACK_WIDTH < 2 || PACK_WIDTH > 32) begin : g_bad_width
        $error("pixel_packer: PACK_WIDTH must be in 2..32");
    end

    pack_state_t           state;
    logic [IDX_W-1:0]      bit_idx;
    logic [PACK_WIDTH-1:0] shift_q;
    logic [PACK_WIDTH-1:0] word_next;
    logic                  completing;
    logic                  out_free;

    // In HOLD the waiting bit is unchanged in S1, so it is still completing;
    // naming the state here keeps the stall sticky and explicit.
    assign completing = (bit_idx == IDX_W'(PACK_WIDTH - 1)) || bit_last || (state == PK_HOLD);
    assign out_free   = !out_valid || out_ready;
    assign bit_accept = bit_valid && (!completing || out_free);

    // shift_q is cleared after every word, so bits above bit_idx are zero.
    assign word_next = shift_q | ({{(PACK_WIDTH-1){1'b0}}, bit_value} << bit_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PK_FILL;
            bit_idx   <= '0;
            shift_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (bit_accept) begin
                if (completing) begin
                    // Overrides the drain above: drain and refill on one edge.
                    out_valid <= 1'b1;
                    out_data  <= word_next;
                    out_count <= 6'(bit_idx) + 6'd1;
                    out_last  <= bit_last;
                    shift_q   <= '0;
                    bit_idx   <= '0;
                end else begin
                    shift_q   <= word_next;
                    bit_idx   <= bit_idx + IDX_W'(1);
                end
            end

            if (bit_valid && completing && !out_free) begin
                state <= PK_HOLD;
            end else begin
                state <= PK_FILL;
            end
        end
    end

endmodule

// File: rtl/color_decoder.sv
// ---------------------------------------------------------------------------
// color_decoder
// Receive-side counterpart of the 1-bit color encoder. Quantizes 24-bit RGB
// pixels to RRRGGGBB, classifies each code to one data bit and packs the bits
// LSB-first into PACK_WIDTH-bit words for the 1-bit frame buffer.
//
// Build option
//   COLOR_DECODER_NEAREST_EN  defined:   bit = 1 iff the code is strictly
//                                         closer to COLOR_1 than to COLOR_0
//                             undefined: bit = (code == COLOR_1)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          pixel handshake (in_ready is combinational)
//   in_red, in_green, in_blue  8-bit pixel channels
//   in_last                    last pixel of a line, flushes a partial word
//   out_valid/out_ready        word handshake
//   out_data                   packed bits, first pixel in bit 0
//   out_count                  valid bits in out_data, 1..PACK_WIDTH
//   out_last                   word ends a line
// ---------------------------------------------------------------------------
module color_decoder
    import color_pkg::*;
#(
    parameter color_code_t COLOR_0    = COLOR_0_DEF,
    parameter color_code_t COLOR_1    = COLOR_1_DEF,
    parameter int          PACK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_red,
    input  logic [7:0]            in_green,
    input  logic [7:0]            in_blue,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic [5:0]            out_count,
    output logic                  out_last
);

    color_code_t code_in;
    color_code_t s1_code;
    logic        s1_valid;
    logic        s1_last;
    logic        s1_bit;
    logic        pk_accept;
    logic        in_fire;
    logic        unused_pixel_lsbs;

    // Keeping only the channel MSBs is the exact inverse of the encoder's
    // 32*R, 32*G, 64*B expansion.
    assign code_in = {in_red[7 -: R_W], in_green[7 -: G_W], in_blue[7 -: B_W]};
    assign unused_pixel_lsbs = ^{in_red[7-R_W:0], in_green[7-G_W:0], in_blue[7-B_W:0]};

    // One-deep stage without a skid buffer: S1 takes a new pixel when it is
    // empty or is handing its pixel to the packer on this same edge.
    assign in_ready = !reset && (!s1_valid || pk_accept);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_last  <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_code  <= code_in;
            s1_last  <= in_last;
        end else if (pk_accept) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef COLOR_DECODER_NEAREST_EN
    // Tie goes to bit 0.
    assign s1_bit = color_dist(s1_code, COLOR_1) < color_dist(s1_code, COLOR_0);
`else
    logic unused_color_0;
    assign unused_color_0 = ^COLOR_0;
    assign s1_bit = (s1_code == COLOR_1);
`endif

    pixel_packer #(
        .PACK_WIDTH (PACK_WIDTH)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (s1_valid),
        .bit_value  (s1_bit),
        .bit_last   (s1_last),
        .bit_accept (pk_accept),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_last   (out_last)
    );

endmodule

// File: tb/tb_color_decoder.sv
module tb_color_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_red, in_green, in_blue;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic [5:0] out_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] q_data[$];
    logic [5:0] q_count[$];
    logic       q_last[$];
    int         q_cyc[$];

    always #5 clk = ~clk;

    color_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    // Word collector: records every completed output handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            q_data.push_back(out_data);
            q_count.push_back(out_count);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic clear_q();
        q_data.delete();
        q_count.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Present one pixel and hold it until accepted (bounded). Leaves in_valid
    // high so consecutive calls stream one pixel per cycle; returns at a
    // falling edge.
    task automatic offer(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic l, output bit ok, output int stalls);
        int t;
        t = 0;
        in_red = r; in_green = g; in_blue = b; in_last = l; in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && t < 64) begin
            @(negedge clk); #1;
            t++;
        end
        ok     = (in_ready === 1'b1);
        stalls = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_words(input int n, output bit ok);
        int t;
        t = 0;
        while (q_data.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic test_reset();
        bit ok; int st;
        @(negedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %0h, expected 0", out_data); end
        vectors++; if (out_count !== 6'd0) begin miscompares++; $display("FAIL reset_out_count: got %0d, expected 0", out_count); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %0b, expected 0", out_last); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b, expected 0", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %0b, expected 1", in_ready); end

        // Reset in the middle of a word: three bits are in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(8'hFF, 8'hFF, 8'hFF, 1'b0, ok, st);
            vectors++; if (!ok) begin miscompares++; $display("FAIL midreset_accept: got stall, expected accept of pixel %0d", i); end
        end
        idle();
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid: got %0b, expected 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL midreset_out_data: got %0h, expected 0", out_data); end
        vectors++; if (out_count !== 6'd0) begin miscompares++; $display("FAIL midreset_out_count: got %0d, expected 0", out_count); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL midreset_out_last: got %0b, expected 0", out_last); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_in_ready: got %0b, expected 0", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (q_data.size() != 0) begin miscompares++; $display("FAIL midreset_no_partial: got %0d words, expected 0", q_data.size()); end

        // The next word must start at bit 0.
        offer(8'hFF, 8'hFF, 8'hFF, 1'b1, ok, st);
        idle();
        wait_words(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL postreset_word: got timeout, expected 1 word"); end
        else begin
            vectors++; if (q_data[0] !== 8'h01) begin miscompares++; $display("FAIL postreset_data: got %0h, expected 01", q_data[0]); end
            vectors++; if (q_count[0] !== 6'd1) begin miscompares++; $display("FAIL postreset_count: got %0d, expected 1", q_count[0]); end
            vectors++; if (q_last[0] !== 1'b1) begin miscompares++; $display("FAIL postreset_last: got %0b, expected 1", q_last[0]); end
        end
        clear_q();
    endtask

    task automatic test_alternating();
        bit ok; int st;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) offer(8'd255, 8'd255, 8'd255, 1'b0, ok, st);
            else            offer(8'd0,   8'd224, 8'd0,   1'b0, ok, st);
            vectors++; if (!ok) begin miscompares++; $display("FAIL alt_accept: got stall, expected accept of pixel %0d", i); end
        end
        idle();
        // The 8th accept cycle ended at the edge just passed (edge 1).
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alt_latency_edge1: got out_valid %0b, expected 0", out_valid); end
        @(negedge clk); #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL alt_latency_edge2: got out_valid %0b, expected 1", out_valid); end
        vectors++; if (out_data !== 8'h55) begin miscompares++; $display("FAIL alt_data: got %0h, expected 55", out_data); end
        vectors++; if (out_count !== 6'd8) begin miscompares++; $display("FAIL alt_count: got %0d, expected 8", out_count); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL alt_last: got %0b, expected 0", out_last); end
        repeat (4) @(negedge clk);
        vectors++; if (q_data.size() != 1) begin miscompares++; $display("FAIL alt_word_count: got %0d words, expected 1", q_data.size()); end
    endtask

    task automatic test_line_flush();
        bit ok; int st;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) offer(8'hFF, 8'hFF, 8'hFF, (i == 2), ok, st);
        idle();
        wait_words(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL flush_word: got timeout, expected 1 word"); end
        else begin
            vectors++; if (q_data[0] !== 8'h07) begin miscompares++; $display("FAIL flush_data: got %0h, expected 07", q_data[0]); end
            vectors++; if (q_count[0] !== 6'd3) begin miscompares++; $display("FAIL flush_count: got %0d, expected 3", q_count[0]); end
            vectors++; if (q_last[0] !== 1'b1) begin miscompares++; $display("FAIL flush_last: got %0b, expected 1", q_last[0]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int st;
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            offer(8'hFF, 8'hFF, 8'hFF, 1'b0, ok, st);
            vectors++; if (!ok) begin miscompares++; $display("FAIL bp_accept: got stall, expected accept of pixel %0d", i); end
        end
        // A 17th pixel must not be taken while the first word is held.
        in_red = 8'h00; in_green = 8'h00; in_blue = 8'h00; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %0b, expected 0 (cycle %0d)", in_ready, c); end
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_count !== 6'd8)
                begin miscompares++; $display("FAIL bp_hold: got valid %0b data %0h count %0d, expected 1 ff 8", out_valid, out_data, out_count); end
            @(negedge clk);
        end
        idle();
        out_ready = 1'b1;
        wait_words(2, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_words: got timeout, expected 2 words"); end
        else begin
            for (int w = 0; w < 2; w++) begin
                vectors++; if (q_data[w] !== 8'hFF || q_count[w] !== 6'd8 || q_last[w] !== 1'b0)
                    begin miscompares++; $display("FAIL bp_word%0d: got %0h/%0d/%0b, expected ff/8/0", w, q_data[w], q_count[w], q_last[w]); end
            end
        end
        // Any lost or duplicated pixel would shift into this flushed word.
        offer(8'h00, 8'h00, 8'h00, 1'b1, ok, st);
        idle();
        wait_words(3, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_tail_word: got timeout, expected 3 words"); end
        else begin
            vectors++; if (q_data[2] !== 8'h00 || q_count[2] !== 6'd1 || q_last[2] !== 1'b1)
                begin miscompares++; $display("FAIL bp_tail: got %0h/%0d/%0b, expected 00/1/1", q_data[2], q_count[2], q_last[2]); end
        end
    endtask

    task automatic test_classify();
        bit ok; int st;
        logic [7:0] exp_data;
        // Codes: F8, 1C, FF, FC, 7E (tie, distance 5 to both).
`ifdef COLOR_DECODER_NEAREST_EN
        exp_data = 8'h0D;
`else
        exp_data = 8'h04;
`endif
        clear_q();
        out_ready = 1'b1;
        offer(8'd255, 8'd200, 8'd0,   1'b0, ok, st);
        offer(8'd0,   8'd255, 8'd0,   1'b0, ok, st);
        offer(8'd255, 8'd255, 8'd255, 1'b0, ok, st);
        offer(8'd255, 8'd255, 8'd0,   1'b0, ok, st);
        offer(8'd96,  8'd224, 8'd128, 1'b1, ok, st);
        idle();
        wait_words(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL class_word: got timeout, expected 1 word"); end
        else begin
            vectors++; if (q_data[0] !== exp_data) begin miscompares++; $display("FAIL class_data: got %0h, expected %0h", q_data[0], exp_data); end
            vectors++; if (q_count[0] !== 6'd5) begin miscompares++; $display("FAIL class_count: got %0d, expected 5", q_count[0]); end
            vectors++; if (q_last[0] !== 1'b1) begin miscompares++; $display("FAIL class_last: got %0b, expected 1", q_last[0]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int st; int total_stalls;
        clear_q();
        out_ready = 1'b1;
        total_stalls = 0;
        for (int i = 0; i < 24; i++) begin
            offer(8'hFF, 8'hFF, 8'hFF, 1'b0, ok, st);
            total_stalls += st;
        end
        idle();
        wait_words(3, ok);
        vectors++; if (total_stalls != 0) begin miscompares++; $display("FAIL b2b_in_ready: got %0d stall cycles, expected 0", total_stalls); end
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_words: got timeout, expected 3 words"); end
        else begin
            for (int w = 0; w < 3; w++) begin
                vectors++; if (q_data[w] !== 8'hFF || q_count[w] !== 6'd8 || q_last[w] !== 1'b0)
                    begin miscompares++; $display("FAIL b2b_word%0d: got %0h/%0d/%0b, expected ff/8/0", w, q_data[w], q_count[w], q_last[w]); end
            end
            vectors++; if (q_cyc[1] - q_cyc[0] != 8) begin miscompares++; $display("FAIL b2b_spacing01: got %0d cycles, expected 8", q_cyc[1] - q_cyc[0]); end
            vectors++; if (q_cyc[2] - q_cyc[1] != 8) begin miscompares++; $display("FAIL b2b_spacing12: got %0d cycles, expected 8", q_cyc[2] - q_cyc[1]); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_red    = 8'h00;
        in_green  = 8'h00;
        in_blue   = 8'h00;
        out_ready = 1'b0;

        test_reset();
        test_alternating();
        test_line_flush();
        test_backpressure();
        test_classify();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
